instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Program-counter and IF/ID pipeline register of the 5-stage processor. Drives the word address into the combinational instruction memory, captures the returned instruction with its PC into the IF/ID register, and handles stalls, taken branches, jumps and pipeline flushes. The decode stage consumes its registered outputs.

## Interface

- width, 32, number of instruction-memory words; PC is a word index of $clog2(width) bits
- wordLength, 32, instruction width in bits
- RESET_PC, 0, PC value loaded on reset
- NOP, 32'h00000013, instruction inserted into IF/ID as a bubble
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- stall  input  1  hazard unit: hold PC and IF/ID contents
- flush  input  1  discard IF/ID contents (insert bubble) without redirecting PC
- branch_taken  input  1  EX stage: taken branch this cycle
- branch_target  input  $clog2(width)  branch destination word index
- jump  input  1  EX stage: jal/jalr this cycle
- jump_target  input  $clog2(width)  jump destination word index
- imem_data  input  wordLength  instruction returned by instruction memory for imem_addr
- imem_addr  output  $clog2(width)  current PC, combinational from PC register
- if_id_instr  output  wordLength  registered instruction for decode
- if_id_pc  output  $clog2(width)  registered PC of if_id_instr
- if_id_pc_plus1  output  $clog2(width)  registered PC+1 (link value for jal)
- if_id_valid  output  1  1 = if_id_instr is a real fetched instruction, 0 = bubble
- fetch_count  output  16  number of instructions accepted into IF/ID since reset, saturating

## Operation

- Reset (rst_n=0, asynchronous): pc=RESET_PC, if_id_instr=NOP, if_id_pc=0, if_id_pc_plus1=0, if_id_valid=0, fetch_count=0. imem_addr follows pc immediately.
- Per-edge priority, highest first: redirect, stall, normal.
- Redirect = branch_taken | jump. If both asserted, jump_target wins. pc <= target; IF/ID <= bubble (instr=NOP, valid=0, pc fields 0). Redirect overrides stall and flush.
- Stall (no redirect): pc and all IF/ID registers hold; fetch_count holds. If flush is also asserted with stall, IF/ID becomes bubble, pc holds.
- Flush alone (no redirect, no stall): pc <= pc+1; IF/ID <= bubble.
- Normal: pc <= pc+1; if_id_instr <= imem_data; if_id_pc <= pc; if_id_pc_plus1 <= pc+1; if_id_valid <= 1; fetch_count increments.
- Arithmetic: pc+1 is modulo width (width a power of two); pc = width-1 wraps to 0 with no error. Targets are taken as-is, no range check.
- fetch_count increments only on normal captures; saturates at 16'hFFFF.

## Timing

- Instruction memory is combinational: imem_data valid in same cycle as imem_addr.
- Fetch latency: instruction at address A appears on if_id_instr one rising edge after pc=A (no stall).
- Redirect penalty: target instruction reaches if_id_instr two edges after the redirect cycle; one bubble (valid=0) in between.
- Stall is level-sensitive; each stalled cycle adds exactly one held cycle; release resumes with the held pc and no lost or duplicated instruction.
- Reset asserted mid-operation clears all state immediately; first valid IF/ID capture occurs on the first rising edge after rst_n deasserts.
- No combinational path from any input to any output except imem_addr (none: driven from pc register).

## Test plan

- Reset then free-run with memory holding instr = 32'hA0+addr: if_id_instr = 32'hA0, 32'hA1, 32'hA2 on edges 1,2,3; if_id_pc = 0,1,2; if_id_pc_plus1 = 1,2,3; fetch_count = 3.
- Stall for 2 cycles at pc=4: imem_addr stays 4, if_id_instr holds addr-3 instr, fetch_count frozen; after release addr 4,5 appear in order.
- branch_taken with branch_target=20 at pc=6: next imem_addr=20, next IF/ID valid=0 with instr=NOP, following IF/ID instr=mem[20], if_id_pc=20.
- branch_taken, jump and stall together, branch_target=8, jump_target=12: pc becomes 12, bubble inserted.
- PC wrap: run from pc=30 with width=32: imem_addr 30,31,0,1; if_id_pc_plus1 for pc=31 is 0.
- Assert rst_n=0 mid-cycle while fetching addr 9: outputs clear without a clock edge; after release fetch restarts at RESET_PC, fetch_count=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register driving a combinational instruction memory,
// IF/ID register with stall, flush, redirect and a saturating fetch counter.
module instruction_fetch_unit #(
    parameter int unsigned width = 32,
    parameter int unsigned wordLength = 32,
    parameter int unsigned RESET_PC = 0,
    parameter logic [wordLength-1:0] NOP = 32'h00000013
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     flush,
    input  logic                     branch_taken,
    input  logic [$clog2(width)-1:0] branch_target,
    input  logic                     jump,
    input  logic [$clog2(width)-1:0] jump_target,
    input  logic [wordLength-1:0]    imem_data,
    output logic [$clog2(width)-1:0] imem_addr,
    output logic [wordLength-1:0]    if_id_instr,
    output logic [$clog2(width)-1:0] if_id_pc,
    output logic [$clog2(width)-1:0] if_id_pc_plus1,
    output logic                     if_id_valid,
    output logic [15:0]              fetch_count
);

    localparam int unsigned AW = $clog2(width);
    localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus1;
    logic [AW-1:0] target;
    logic          redirect;
    logic          bubble;
    logic          capture;

    // width is a power of two, so the AW-bit add wraps modulo width
    assign pc_plus1 = pc + AW'(1);
    assign redirect = branch_taken | jump;
    assign target   = jump ? jump_target : branch_target;
    assign bubble   = redirect | flush;
    assign capture  = !redirect && !stall && !flush;
    assign imem_addr = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RST_PC;
        end else if (redirect) begin
            pc <= target;
        end else if (!stall) begin
            pc <= pc_plus1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_instr    <= NOP;
            if_id_pc       <= '0;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
        end else if (bubble) begin
            if_id_instr    <= NOP;
            if_id_pc       <= '0;
            if_id_pc_plus1 <= '0;
            if_id_valid    <= 1'b0;
        end else if (capture) begin
            if_id_instr    <= imem_data;
            if_id_pc       <= pc;
            if_id_pc_plus1 <= pc_plus1;
            if_id_valid    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count <= '0;
        end else if (capture && fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random control
// traffic compared against a behavioural fetch model.
module tb_instruction_fetch_unit;

    localparam int W = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall, flush, branch_taken, jump;
    logic [4:0]  branch_target, jump_target;
    logic [31:0] imem_data;
    logic [4:0]  imem_addr;
    logic [31:0] if_id_instr;
    logic [4:0]  if_id_pc, if_id_pc_plus1;
    logic        if_id_valid;
    logic [15:0] fetch_count;

    logic [31:0] mem [W];

    int checks = 0;
    int errors = 0;

    int          m_pc, m_ipc, m_ipc1, m_cnt;
    logic [31:0] m_instr;
    logic        m_valid;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    instruction_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target), .imem_data(imem_data),
        .imem_addr(imem_addr), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .if_id_pc_plus1(if_id_pc_plus1),
        .if_id_valid(if_id_valid), .fetch_count(fetch_count)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ipc = 0; m_ipc1 = 0; m_cnt = 0;
        m_instr = NOP; m_valid = 1'b0;
    endtask

    task automatic model_bubble();
        m_instr = NOP; m_valid = 1'b0; m_ipc = 0; m_ipc1 = 0;
    endtask

    task automatic compare_all();
        chk("imem_addr", 32'(imem_addr), m_pc);
        chk("if_id_instr", if_id_instr, m_instr);
        chk("if_id_pc", 32'(if_id_pc), m_ipc);
        chk("if_id_pc_plus1", 32'(if_id_pc_plus1), m_ipc1);
        chk("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        chk("fetch_count", 32'(fetch_count), m_cnt);
    endtask

    task automatic step(input logic br, input int bt, input logic jp,
                        input int jt, input logic st, input logic fl);
        branch_taken = br; branch_target = 5'(bt);
        jump = jp; jump_target = 5'(jt);
        stall = st; flush = fl;
        if (br || jp) begin
            m_pc = jp ? jt : bt;
            model_bubble();
        end else if (st) begin
            if (fl) model_bubble();
        end else if (fl) begin
            m_pc = (m_pc + 1) % W;
            model_bubble();
        end else begin
            m_instr = mem[m_pc];
            m_ipc = m_pc;
            m_ipc1 = (m_pc + 1) % W;
            m_valid = 1'b1;
            if (m_cnt < 65535) m_cnt++;
            m_pc = (m_pc + 1) % W;
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic normal();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic async_reset_check();
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst_instr_nop", if_id_instr, NOP);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        stall = 0; flush = 0; branch_taken = 0; jump = 0;
        branch_target = 0; jump_target = 0;
        for (int i = 0; i < W; i++) mem[i] = 32'hA0 + i;
        model_reset();
        #12;
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;

        normal(); chk("free_run_e1", if_id_instr, 32'hA0);
        normal(); chk("free_run_e2", if_id_instr, 32'hA1);
        normal();
        chk("free_run_e3", if_id_instr, 32'hA2);
        chk("free_run_pc", 32'(if_id_pc), 2);
        chk("free_run_pc1", 32'(if_id_pc_plus1), 3);
        chk("free_run_cnt", 32'(fetch_count), 3);

        normal();
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("stall_addr", 32'(imem_addr), 4);
        chk("stall_instr", if_id_instr, 32'hA3);
        chk("stall_cnt", 32'(fetch_count), 4);
        normal(); chk("stall_rel1", if_id_instr, 32'hA4);
        normal(); chk("stall_rel2", if_id_instr, 32'hA5);

        step(1, 20, 0, 0, 0, 0);
        chk("br_addr", 32'(imem_addr), 20);
        chk("br_bubble", if_id_instr, NOP);
        chk("br_valid", 32'(if_id_valid), 0);
        normal();
        chk("br_target_instr", if_id_instr, 32'hA0 + 20);
        chk("br_target_pc", 32'(if_id_pc), 20);

        step(1, 8, 1, 12, 1, 0);
        chk("br_jmp_stall_addr", 32'(imem_addr), 12);
        chk("br_jmp_stall_valid", 32'(if_id_valid), 0);

        step(0, 0, 0, 0, 1, 1);
        chk("stall_flush_addr", 32'(imem_addr), 12);
        step(0, 0, 0, 0, 0, 1);
        chk("flush_addr", 32'(imem_addr), 13);

        step(0, 0, 1, 30, 0, 0);
        normal(); chk("wrap_a31", 32'(imem_addr), 31);
        normal(); chk("wrap_a0", 32'(imem_addr), 0);
        chk("wrap_pc1", 32'(if_id_pc_plus1), 0);
        normal(); chk("wrap_a1", 32'(imem_addr), 1);

        step(0, 0, 1, 9, 0, 0);
        async_reset_check();
        normal();
        chk("post_rst_instr", if_id_instr, 32'hA0);
        chk("post_rst_cnt", 32'(fetch_count), 1);

        for (int i = 0; i < W; i++) mem[i] = $urandom;
        for (int n = 0; n < 400; n++) begin
            automatic int r  = $urandom_range(0, 99);
            automatic logic br = (r < 8);
            automatic logic jp = ($urandom_range(0, 99) < 8);
            automatic logic st = ($urandom_range(0, 99) < 20);
            automatic logic fl = ($urandom_range(0, 99) < 10);
            step(br, $urandom_range(0, W - 1), jp, $urandom_range(0, W - 1),
                 st, fl);
            if (n == 200) async_reset_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
